// File: rtl/apb_slave_mem_if.sv
// apb_slave_mem_if: APB bus signals between a master and the apb_slave_mem slave
interface apb_slave_mem_if;
  logic [1:0] pselx;
  logic penable;
  logic pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic pready;
  logic [31:0] prdata;
  logic pslverr;
  modport master (output pselx, penable, pwrite, paddr, pwdata, input pready, prdata, pslverr);
  modport slave (input pselx, penable, pwrite, paddr, pwdata, output pready, prdata, pslverr);
endinterface

// File: rtl/apb_slave_mem.sv
// apb_slave_mem: APB slave with a 16-word register file, configurable wait states and error response
module apb_slave_mem #(
  parameter logic [1:0] SLV_ID = 2'b01,
  parameter int WAIT_CYCLES = 2,
  parameter logic [31:0] ID_VALUE = 32'hA0B0_0001
) (
  input logic pclk,
  input logic prst,
  apb_slave_mem_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, next_state;
  logic [3:0] cnt, next_cnt, idx;
  logic [31:0] addr, wdata, cur_addr, cur_wdata;
  logic [31:0] mem [16];
  logic write, cur_write, sel, capture, enter_resp, err;
  assign sel = bus.pselx == SLV_ID && bus.penable;
  always_comb begin
    next_state = state;
    next_cnt = cnt;
    capture = 1'b0;
    case (state)
      IDLE: if (sel) begin
        capture = 1'b1;
        next_state = WAIT_CYCLES > 0 ? WAIT : RESP;
        next_cnt = WAIT_CYCLES > 0 ? 4'(WAIT_CYCLES - 1) : 4'd0;
      end
      WAIT: next_state = !sel ? IDLE : cnt == 4'd0 ? RESP : WAIT;
      default: next_state = IDLE;
    endcase
    if (state == WAIT && sel && cnt != 4'd0) next_cnt = cnt - 4'd1;
  end
  // With zero wait cycles the response is formed from the live bus on the capture edge
  assign cur_addr = state == IDLE ? bus.paddr : addr;
  assign cur_wdata = state == IDLE ? bus.pwdata : wdata;
  assign cur_write = state == IDLE ? bus.pwrite : write;
  assign idx = cur_addr[5:2];
  assign err = cur_addr[31:6] != '0 || cur_addr[1:0] != 2'b00 || (cur_write && idx == 4'hF);
  assign enter_resp = next_state == RESP && state != RESP;
  always_ff @(posedge pclk) begin
    if (!prst) begin
      state <= IDLE;
      cnt <= '0;
      addr <= '0;
      wdata <= '0;
      write <= 1'b0;
      bus.pready <= 1'b0;
      bus.pslverr <= 1'b0;
      bus.prdata <= '0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      state <= next_state;
      cnt <= next_cnt;
      if (capture) begin
        addr <= bus.paddr;
        wdata <= bus.pwdata;
        write <= bus.pwrite;
      end
      bus.pready <= enter_resp;
      bus.pslverr <= enter_resp && err;
      if (enter_resp && cur_write && !err) mem[idx] <= cur_wdata;
      if (enter_resp && !cur_write) bus.prdata <= err ? '0 : idx == 4'hF ? ID_VALUE : mem[idx];
    end
  end
endmodule

// File: tb/tb_apb_slave_mem.sv
// tb_apb_slave_mem: randomized scoreboard bench for apb_slave_mem with 2 and 0 wait cycles
module tb_apb_slave_mem;
  localparam logic [31:0] ID = 32'hA0B0_0001;
  typedef struct {
    logic [31:0] rdata;
    logic err;
    int start;
  } exp_t;
  logic clk = 1'b0;
  logic rst0 = 1'b0;
  logic rst1 = 1'b0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [31:0] m [2][16];
  logic [31:0] last [2];
  int lat [2] = '{3, 1};
  apb_slave_mem_if b0 ();
  apb_slave_mem_if b1 ();
  apb_slave_mem #(.SLV_ID(2'b01), .WAIT_CYCLES(2), .ID_VALUE(ID)) dut0 (.pclk(clk), .prst(rst0), .bus(b0));
  apb_slave_mem #(.SLV_ID(2'b01), .WAIT_CYCLES(0), .ID_VALUE(ID)) dut1 (.pclk(clk), .prst(rst1), .bus(b1));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic pr(int d);
    return d == 0 ? b0.pready : b1.pready;
  endfunction
  task automatic set_bus(int d, logic [1:0] s, logic e, logic w, logic [31:0] a, logic [31:0] wd);
    if (d == 0) begin
      b0.pselx = s; b0.penable = e; b0.pwrite = w; b0.paddr = a; b0.pwdata = wd;
    end else begin
      b1.pselx = s; b1.penable = e; b1.pwrite = w; b1.paddr = a; b1.pwdata = wd;
    end
  endtask
  // Reference model: word-addressed array, legality by plain arithmetic on the byte address
  task automatic expect_xfer(int d, logic w, logic [31:0] a, logic [31:0] wd, int start);
    exp_t e;
    int i;
    logic bad;
    i = int'(a % 64) / 4;
    bad = (a >= 64) || (a % 4 != 0) || (w && i == 15);
    if (w) begin
      if (!bad) m[d][i] = wd;
      e.rdata = last[d];
    end else begin
      e.rdata = bad ? 32'h0 : (i == 15 ? ID : m[d][i]);
      last[d] = e.rdata;
    end
    e.err = bad;
    e.start = start;
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask
  task automatic model_reset(int d);
    for (int i = 0; i < 16; i++) m[d][i] = '0;
    last[d] = '0;
  endtask
  task automatic mon(int d, logic [31:0] rd, logic er);
    exp_t e;
    if ((d == 0 ? q0.size() : q1.size()) == 0) begin
      chk($sformatf("unexpected_pready[%0d]", d), 32'd1, 32'd0);
      return;
    end
    if (d == 0) e = q0.pop_front();
    else e = q1.pop_front();
    chk($sformatf("prdata[%0d]", d), rd, e.rdata);
    chk($sformatf("pslverr[%0d]", d), 32'(er), 32'(e.err));
    chk($sformatf("latency[%0d]", d), 32'(cyc - e.start), 32'(lat[d]));
  endtask
  always @(negedge clk) if (b0.pready === 1'b1) mon(0, b0.prdata, b0.pslverr);
  always @(negedge clk) if (b1.pready === 1'b1) mon(1, b1.prdata, b1.pslverr);
  // hold keeps the access asserted through RESP; chained starts right at that RESP cycle
  task automatic xfer(int d, logic w, logic [31:0] a, logic [31:0] wd, bit hold = 0, bit chained = 0);
    int start;
    bit done = 0;
    if (!chained) @(negedge clk);
    start = chained ? cyc + 1 : cyc;
    set_bus(d, 2'b01, 1'b1, w, a, wd);
    expect_xfer(d, w, a, wd, start);
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (pr(d)) done = 1;
      else if (k == 0 && !chained) set_bus(d, 2'b01, 1'b1, 1'($urandom), $urandom, $urandom);
    end
    if (!done) chk($sformatf("timeout[%0d]", d), 32'd0, 32'd1);
    if (!hold) set_bus(d, 2'b00, 1'b0, 1'b0, '0, '0);
  endtask
  task automatic quiet(string name, int n);
    logic seen = 1'b0;
    repeat (n) begin
      @(negedge clk);
      seen |= pr(0);
    end
    chk(name, 32'(seen), 32'd0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic w;
    logic [31:0] a;
    int d;
    set_bus(0, 2'b00, 1'b0, 1'b0, '0, '0);
    set_bus(1, 2'b00, 1'b0, 1'b0, '0, '0);
    model_reset(0);
    model_reset(1);
    repeat (3) @(negedge clk);
    chk("reset_pready0", 32'(b0.pready), 32'd0);
    chk("reset_pslverr0", 32'(b0.pslverr), 32'd0);
    chk("reset_prdata0", b0.prdata, 32'd0);
    chk("reset_pready1", 32'(b1.pready), 32'd0);
    rst0 = 1'b1;
    rst1 = 1'b1;
    xfer(0, 1, 32'h08, 32'hDEADBEEF);
    xfer(0, 0, 32'h08, 32'h0);
    xfer(0, 0, 32'h3C, 32'h0);
    xfer(0, 1, 32'h3C, 32'h11111111);
    xfer(0, 0, 32'h3C, 32'h0);
    xfer(0, 0, 32'h40, 32'h0);
    xfer(0, 1, 32'h05, 32'h22222222);
    xfer(0, 0, 32'h04, 32'h0);
    xfer(0, 1, 32'h0C, 32'h0C0C0C0C);
    @(negedge clk);
    set_bus(0, 2'b01, 1'b1, 1'b1, 32'h0C, 32'h12345678);
    @(negedge clk);
    set_bus(0, 2'b01, 1'b0, 1'b1, 32'h0C, 32'h12345678);
    quiet("abort_no_pready", 6);
    set_bus(0, 2'b00, 1'b0, 1'b0, '0, '0);
    xfer(0, 0, 32'h0C, 32'h0);
    @(negedge clk);
    set_bus(0, 2'b10, 1'b1, 1'b1, 32'h08, 32'h0BADF00D);
    quiet("deselect_no_pready", 6);
    set_bus(0, 2'b00, 1'b0, 1'b0, '0, '0);
    xfer(0, 0, 32'h08, 32'h0);
    @(negedge clk);
    set_bus(0, 2'b01, 1'b1, 1'b1, 32'h10, 32'hCAFEF00D);
    @(negedge clk);
    rst0 = 1'b0;
    @(negedge clk);
    chk("rst_wait_pready", 32'(b0.pready), 32'd0);
    chk("rst_wait_prdata", b0.prdata, 32'd0);
    chk("rst_wait_pslverr", 32'(b0.pslverr), 32'd0);
    rst0 = 1'b1;
    set_bus(0, 2'b00, 1'b0, 1'b0, '0, '0);
    model_reset(0);
    xfer(0, 0, 32'h10, 32'h0);
    xfer(0, 0, 32'h08, 32'h0);
    xfer(0, 1, 32'h10, 32'h5A5A5A5A);
    xfer(0, 0, 32'h10, 32'h0);
    xfer(1, 1, 32'h00, 32'hAAAA0000, 1, 0);
    xfer(1, 1, 32'h04, 32'hBBBB0004, 0, 1);
    xfer(1, 0, 32'h00, 32'h0);
    xfer(1, 0, 32'h04, 32'h0);
    xfer(1, 0, 32'h3C, 32'h0);
    for (int i = 0; i < 60; i++) begin
      d = i % 2;
      w = 1'($urandom);
      a = ($urandom % 4 == 0) ? 32'($urandom_range(0, 127)) : 32'(4 * $urandom_range(0, 15));
      xfer(d, w, a, $urandom);
    end
    repeat (5) @(negedge clk);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb_slave_mem.md
APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

Interface
REQ-001 The block SHALL have parameter SLV_ID, default 2'b01, the pselx code that selects this slave.
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, the number of wait cycles inserted before pready (legal range 0..15).
REQ-003 The block SHALL have parameter ID_VALUE, default 32'hA0B0_0001, the read-only constant at word 15.
REQ-004 pclk  input  1  the single clock; all state changes occur on the rising edge.
REQ-005 prst  input  1  reset: synchronous and active-low, sampled on the rising edge of pclk.
REQ-006 pselx  input  2  slave select from the master; the block is selected when pselx == SLV_ID.
REQ-007 penable  input  1  APB access-phase indicator from the master.
REQ-008 pwrite  input  1  1 = write, 0 = read.
REQ-009 paddr  input  32  byte address.
REQ-010 pwdata  input  32  write data.
REQ-011 pready  output  1  registered transfer-complete strobe to the master.
REQ-012 prdata  output  32  registered read data, valid while pready = 1 on a read.
REQ-013 pslverr  output  1  registered error flag, valid while pready = 1.

Function
REQ-014 Storage SHALL be 16 x 32-bit words, indexed by paddr[5:2]; words 0..14 are read/write and word 15 reads ID_VALUE.
REQ-015 An address SHALL be legal only if paddr[31:6] == 0 and paddr[1:0] == 0.
REQ-016 The FSM SHALL have three states: IDLE, WAIT and RESP, with reset state IDLE.
REQ-017 IDLE: if pselx == SLV_ID and penable == 1, the block SHALL capture paddr, pwrite and pwdata.
REQ-018 IDLE, on that capture: the block SHALL go to WAIT with the counter loaded to WAIT_CYCLES-1 if WAIT_CYCLES > 0, otherwise go directly to RESP.
REQ-019 IDLE: in all other cases the block SHALL stay in IDLE.
REQ-020 WAIT: if pselx != SLV_ID or penable == 0, the transfer SHALL be aborted: return to IDLE, no write, pready stays 0.
REQ-021 WAIT: otherwise, with counter == 0 the block SHALL go to RESP; with counter > 0 it SHALL decrement the counter and stay in WAIT.
REQ-022 The edge entering RESP SHALL set pready = 1 and set pslverr according to REQ-024.
REQ-023 On that same edge, the block SHALL perform the memory write (legal, non-protected writes only) and load prdata.
REQ-024 pslverr SHALL be 1 for an illegal address, or for a write to word 15; otherwise 0.
REQ-025 RESP SHALL last exactly one cycle, then the FSM SHALL go to IDLE with pready = 0 and pslverr = 0.
REQ-026 Latency: penable is first sampled high in IDLE at cycle T; pready SHALL be high in cycle T+1+WAIT_CYCLES, for exactly one cycle.
REQ-027 A read SHALL load prdata with mem[index] (or ID_VALUE for word 15); an erroring read SHALL load 0.
REQ-028 A write SHALL NOT change prdata.
REQ-029 An erroring write SHALL leave memory unchanged.
REQ-030 Captured values SHALL be used for the whole transfer; changes on paddr, pwdata or pwrite after capture are ignored.
REQ-031 A new transfer SHALL NOT be accepted in RESP; penable still high in the cycle after RESP SHALL start a new transfer from IDLE.
REQ-032 Signals presented while pselx != SLV_ID SHALL have no effect.

Reset
REQ-033 While prst == 0 at a rising edge, the FSM SHALL go to IDLE and the counter SHALL clear to 0.
REQ-034 While prst == 0 at a rising edge, pready, pslverr and prdata SHALL clear to 0, and memory words 0..14 SHALL clear to 0.
REQ-035 Reset asserted in WAIT or RESP SHALL abandon the transfer with no memory write, and pready SHALL be 0 in the next cycle.
REQ-036 After prst returns high, the block SHALL accept a transfer from the first edge at which it is selected.

Verification
REQ-037 Write with WAIT_CYCLES = 2: pselx = 01, paddr = 0x08, pwdata = 0xDEADBEEF, penable high at T -> pready = 1 only at T+3, pslverr = 0, mem[2] = 0xDEADBEEF.
REQ-038 Read back paddr = 0x08 -> pready at T+3, prdata = 0xDEADBEEF, pslverr = 0; then read paddr = 0x3C -> prdata = 0xA0B00001.
REQ-039 Error cases: write to paddr = 0x3C -> pslverr = 1 and word 15 still reads ID_VALUE; read of paddr = 0x40 -> pslverr = 1, prdata = 0; write to paddr = 0x05 -> pslverr = 1, no write.
REQ-040 Abort and deselect: penable dropped at T+1 during WAIT -> no pready and memory unchanged; transfer with pselx = 10 -> no pready and memory unchanged.
REQ-041 WAIT_CYCLES = 0: penable high at T -> pready at T+1; back-to-back writes to 0x00 and then 0x04 -> both words written, one pready each.
REQ-042 Reset mid-WAIT: prst = 0 during a write to 0x10 -> pready = 0, mem[4] = 0, prdata = 0; the next transfer completes normally.
